// File: rtl/cipher_channel_arbiter.sv
// -----------------------------------------------------------------------------
// cipher_channel_arbiter
//
// Purpose: two plaintext channels share one counter-mode S-box keystream
// datapath. Each channel owns an 8-bit counter block that is seeded by its
// session key on load. Character slots are arbitrated round-robin with a
// burst limit. Each accepted character leaves one cycle later as a
// registered ciphertext character, tagged with its channel, and held under
// downstream backpressure.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   key0/key1   [7:0] in    session key, sampled when loadN is high
//   load0/load1       in    session start, cbN <= keyN
//   ptxt0/ptxt1 [7:0] in    plaintext character
//   valid0/valid1     in    plaintext character valid
//   ready0/ready1     out   character accepted this cycle
//   ctxt        [7:0] out   ciphertext character
//   ctxt_ch           out   channel that ctxt belongs to
//   dout_valid        out   ctxt/ctxt_ch valid
//   dout_ready        in    downstream takes the output this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

// Combinational byte substitution table, in[7:0] -> out[7:0] (AES S-box).
module sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  localparam logic [7:0] TBL [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out = TBL[in];
endmodule

// FSM states:
//   state  | meaning
//   IDLE   | no channel owns the datapath; next grant breaks ties on last
//   SERVE0 | channel 0 holds the slot, burst counts its consecutive grants
//   SERVE1 | channel 1 holds the slot, burst counts its consecutive grants
module cipher_channel_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key0,
  input  logic       load0,
  input  logic [7:0] ptxt0,
  input  logic       valid0,
  output logic       ready0,
  input  logic [7:0] key1,
  input  logic       load1,
  input  logic [7:0] ptxt1,
  input  logic       valid1,
  output logic       ready1,
  output logic [7:0] ctxt,
  output logic       ctxt_ch,
  output logic       dout_valid,
  input  logic       dout_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic [7:0] cb0_q, cb0_d, cb1_q, cb1_d;
  logic       keyed0_q, keyed1_q;
  logic [7:0] ctxt_q, ctxt_d;
  logic       ctxt_ch_q, ctxt_ch_d;
  logic       dv_q, dv_d;

  logic       out_free;
  logic       elig0, elig1;
  logic       grant_any, grant_ch;
  logic       xfer;
  logic [7:0] sbox_in, sbox_out;

  assign out_free = !dv_q || dout_ready;
  assign elig0    = valid0 && keyed0_q && !load0;
  assign elig1    = valid1 && keyed1_q && !load1;

  always_comb begin
    grant_any = 1'b0;
    grant_ch  = 1'b0;
    case (state_q)
      SERVE0: begin
        if (elig0 && ((burst_q < BURST_MAX) || !elig1)) begin
          grant_any = 1'b1;
          grant_ch  = 1'b0;
        end else if (elig1) begin
          grant_any = 1'b1;
          grant_ch  = 1'b1;
        end
      end
      SERVE1: begin
        if (elig1 && ((burst_q < BURST_MAX) || !elig0)) begin
          grant_any = 1'b1;
          grant_ch  = 1'b1;
        end else if (elig0) begin
          grant_any = 1'b1;
          grant_ch  = 1'b0;
        end
      end
      default: begin
        // Tie goes to the channel that was not served last.
        if (elig0 && elig1) begin
          grant_any = 1'b1;
          grant_ch  = !last_q;
        end else if (elig0) begin
          grant_any = 1'b1;
          grant_ch  = 1'b0;
        end else if (elig1) begin
          grant_any = 1'b1;
          grant_ch  = 1'b1;
        end
      end
    endcase
  end

  assign ready0 = out_free && keyed0_q && !load0 && grant_any && !grant_ch;
  assign ready1 = out_free && keyed1_q && !load1 && grant_any && grant_ch;
  assign xfer   = out_free && grant_any;

  // The single S-box instance sees whichever counter block wins the grant.
  assign sbox_in = grant_ch ? cb1_q : cb0_q;

  sbox u_sbox (
    .in  (sbox_in),
    .out (sbox_out)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    cb0_d     = cb0_q;
    cb1_d     = cb1_q;
    ctxt_d    = ctxt_q;
    ctxt_ch_d = ctxt_ch_q;
    dv_d      = dv_q;

    if (xfer) begin
      ctxt_d    = (grant_ch ? ptxt1 : ptxt0) ^ sbox_out;
      ctxt_ch_d = grant_ch;
      dv_d      = 1'b1;
      // 8-bit increment wraps FF -> 00.
      if (grant_ch) cb1_d = cb1_q + 8'd1;
      else          cb0_d = cb0_q + 8'd1;

      if (state_q == (grant_ch ? SERVE1 : SERVE0)) begin
        burst_d = (burst_q < BURST_MAX) ? burst_q + 4'd1 : burst_q;
      end else begin
        state_d = grant_ch ? SERVE1 : SERVE0;
        burst_d = 4'd1;
        last_d  = grant_ch;
      end
    end else if (out_free) begin
      dv_d    = 1'b0;
      state_d = IDLE;
    end

    // A load wins over any counter update on its own channel.
    if (load0) cb0_d = key0;
    if (load1) cb1_d = key1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      burst_q   <= 4'd0;
      cb0_q     <= 8'h00;
      cb1_q     <= 8'h00;
      keyed0_q  <= 1'b0;
      keyed1_q  <= 1'b0;
      ctxt_q    <= 8'h00;
      ctxt_ch_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      cb0_q     <= cb0_d;
      cb1_q     <= cb1_d;
      keyed0_q  <= keyed0_q | load0;
      keyed1_q  <= keyed1_q | load1;
      ctxt_q    <= ctxt_d;
      ctxt_ch_q <= ctxt_ch_d;
      dv_q      <= dv_d;
    end
  end

  assign ctxt       = ctxt_q;
  assign ctxt_ch    = ctxt_ch_q;
  assign dout_valid = dv_q;

endmodule

// File: tb/tb_cipher_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cipher_channel_arbiter
//
// Purpose: self-checking bench for cipher_channel_arbiter. The reference
// keeps each channel's counter block, the current slot owner with its run
// length, and the output register contents. The S-box reference is built
// from GF(2^8) inversion plus the affine map.
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cipher_channel_arbiter;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key0 = 8'h00, key1 = 8'h00, ptxt0 = 8'h00, ptxt1 = 8'h00;
  logic       load0 = 1'b0, load1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
  logic       dout_ready = 1'b1;
  logic       ready0, ready1, ctxt_ch, dout_valid;
  logic [7:0] ctxt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_ref [256];

  // reference state
  bit         m_keyed [2];
  logic [7:0] m_cb    [2];
  int         m_owner, m_run, m_last;
  bit         m_dv, m_ch;
  logic [7:0] m_ctxt;
  logic [1:0] exp_rdy;

  cipher_channel_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key0       (key0),
    .load0      (load0),
    .ptxt0      (ptxt0),
    .valid0     (valid0),
    .ready0     (ready0),
    .key1       (key1),
    .load1      (load1),
    .ptxt1      (ptxt1),
    .valid1     (valid1),
    .ready1     (ready1),
    .ctxt       (ctxt),
    .ctxt_ch    (ctxt_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Channel the arbitration rules award this cycle, -1 for none.
  function automatic int pick();
    bit e [2];
    int o, m;
    e[0] = valid0 && m_keyed[0] && !load0;
    e[1] = valid1 && m_keyed[1] && !load1;
    if (m_owner < 0) begin
      if (e[0] && e[1]) return 1 - m_last;
      if (e[0]) return 0;
      if (e[1]) return 1;
      return -1;
    end
    o = m_owner;
    m = 1 - o;
    if (e[o] && (m_run < MAXB || !e[m])) return o;
    if (e[m]) return m;
    return -1;
  endfunction

  task automatic mdl_reset();
    m_keyed[0] = 1'b0; m_keyed[1] = 1'b0;
    m_cb[0] = 8'h00;   m_cb[1] = 8'h00;
    m_owner = -1; m_run = 0; m_last = 1;
    m_dv = 1'b0; m_ch = 1'b0; m_ctxt = 8'h00;
  endtask

  task automatic predict();
    int g;
    bit free;
    #2;
    free = !m_dv || dout_ready;
    g = pick();
    exp_rdy = {free && (g == 1), free && (g == 0)};
  endtask

  task automatic advance();
    int g;
    bit free;
    @(posedge clk);
    if (rst_n) begin
      free = !m_dv || dout_ready;
      g = pick();
      if (free) begin
        if (g >= 0) begin
          m_ctxt = ((g == 0) ? ptxt0 : ptxt1) ^ sb_ref[m_cb[g]];
          m_ch   = (g == 1);
          m_dv   = 1'b1;
          m_cb[g] = m_cb[g] + 8'd1;
          if (g == m_owner) m_run++;
          else begin m_owner = g; m_run = 1; m_last = g; end
        end else begin
          m_dv = 1'b0;
          m_owner = -1;
        end
      end
      if (load0) begin m_keyed[0] = 1'b1; m_cb[0] = key0; end
      if (load1) begin m_keyed[1] = 1'b1; m_cb[1] = key1; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    load0 = 1'b0; load1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    dout_ready = 1'b1;
    rst_n = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({dout_valid, ctxt_ch, ctxt} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b ch=%b c=%h want 0 0 00", dout_valid, ctxt_ch, ctxt);
    end
    for (int i = 0; i < 2; i++) begin
      valid0 = 1'b1; valid1 = 1'b1;
      predict();
      n_checks++;
      if ({ready1, ready0} !== 2'b00) begin
        n_fail++; $display("FAIL reset_ready cyc %0d: got %b want 00", i, {ready1, ready0});
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_single_channel();
    load0 = 1'b1; key0 = 8'h10;
    predict(); advance();
    load0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid0 = (i < 3); ptxt0 = 8'(8'h41 + i);
      predict();
      n_checks++;
      if ({ready1, ready0} !== exp_rdy) begin
        n_fail++; $display("FAIL single_ready cyc %0d: got %b want %b", i, {ready1, ready0}, exp_rdy);
      end
      advance();
      n_checks++;
      if (i < 3) begin
        if (dout_valid !== 1'b1 || ctxt_ch !== 1'b0 || ctxt !== (8'(8'h41 + i) ^ sb_ref[8'(8'h10 + i)])) begin
          n_fail++;
          $display("FAIL single_out cyc %0d: got v=%b ch=%b c=%h want 1 0 %h", i, dout_valid, ctxt_ch, ctxt,
                   8'(8'h41 + i) ^ sb_ref[8'(8'h10 + i)]);
        end
      end else if (dout_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_drain: got v=%b want 0", dout_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [7:0] p;
    load1 = 1'b1; key1 = 8'hFE;
    predict(); advance();
    load1 = 1'b0;
    // fourth character shows where cb1 ended after FE, FF, 00
    for (int i = 0; i < 4; i++) begin
      valid1 = 1'b1; p = 8'($urandom); ptxt1 = p;
      predict();
      n_checks++;
      if ({ready1, ready0} !== exp_rdy) begin
        n_fail++; $display("FAIL wrap_ready cyc %0d: got %b want %b", i, {ready1, ready0}, exp_rdy);
      end
      advance();
      n_checks++;
      if (dout_valid !== 1'b1 || ctxt_ch !== 1'b1 || ctxt !== (p ^ sb_ref[8'(8'hFE + i)])) begin
        n_fail++;
        $display("FAIL wrap_out cyc %0d: got v=%b ch=%b c=%h want 1 1 %h", i, dout_valid, ctxt_ch, ctxt,
                 p ^ sb_ref[8'(8'hFE + i)]);
      end
    end
    idle_inputs();
    predict(); advance();
  endtask

  task automatic test_fairness();
    bit [11:0]  seq;
    logic [7:0] p0, p1, want;
    int n0, n1;
    bit ch;
    seq = 12'b0000_1111_0000;
    n0 = 0; n1 = 0;
    do_reset();
    load0 = 1'b1; key0 = 8'h20; load1 = 1'b1; key1 = 8'hA0;
    predict(); advance();
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      valid0 = 1'b1; valid1 = 1'b1;
      p0 = 8'($urandom); p1 = 8'($urandom); ptxt0 = p0; ptxt1 = p1;
      predict();
      n_checks++;
      if ({ready1, ready0} !== exp_rdy) begin
        n_fail++; $display("FAIL fair_ready cyc %0d: got %b want %b", i, {ready1, ready0}, exp_rdy);
      end
      advance();
      ch = seq[i];
      want = ch ? (p1 ^ sb_ref[8'(8'hA0 + n1)]) : (p0 ^ sb_ref[8'(8'h20 + n0)]);
      if (ch) n1++; else n0++;
      n_checks++;
      if (dout_valid !== 1'b1 || ctxt_ch !== ch || ctxt !== want) begin
        n_fail++;
        $display("FAIL fair_out cyc %0d: got v=%b ch=%b c=%h want 1 %b %h", i, dout_valid, ctxt_ch, ctxt, ch, want);
      end
    end
    idle_inputs();
    predict(); advance();
  endtask

  task automatic test_back_to_back_backpressure();
    logic [9:0] held;
    valid0 = 1'b1; ptxt0 = 8'($urandom); dout_ready = 1'b1;
    predict(); advance();
    held = {dout_valid, ctxt_ch, ctxt};
    n_checks++;
    if (dout_valid !== m_dv || {ctxt_ch, ctxt} !== {m_ch, m_ctxt}) begin
      n_fail++; $display("FAIL bp_first: got ch=%b c=%h want %b %h", ctxt_ch, ctxt, m_ch, m_ctxt);
    end
    for (int i = 0; i < 3; i++) begin
      dout_ready = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
      ptxt0 = 8'($urandom); ptxt1 = 8'($urandom);
      predict();
      n_checks++;
      if ({ready1, ready0} !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready cyc %0d: got %b want 00", i, {ready1, ready0});
      end
      advance();
      n_checks++;
      if ({dout_valid, ctxt_ch, ctxt} !== held) begin
        n_fail++; $display("FAIL bp_hold cyc %0d: got %h want %h", i, {dout_valid, ctxt_ch, ctxt}, held);
      end
    end
    dout_ready = 1'b1;
    predict();
    n_checks++;
    if ({ready1, ready0} !== exp_rdy || (ready0 | ready1) !== 1'b1) begin
      n_fail++; $display("FAIL bp_resume_ready: got %b want %b", {ready1, ready0}, exp_rdy);
    end
    advance();
    n_checks++;
    if (dout_valid !== 1'b1 || {ctxt_ch, ctxt} !== {m_ch, m_ctxt}) begin
      n_fail++;
      $display("FAIL bp_resume_out: got v=%b ch=%b c=%h want 1 %b %h", dout_valid, ctxt_ch, ctxt, m_ch, m_ctxt);
    end
    idle_inputs();
    predict(); advance();
  endtask

  task automatic test_load_collision();
    logic [7:0] p;
    do_reset();
    valid1 = 1'b1; ptxt1 = 8'($urandom);
    load0 = 1'b1; key0 = 8'h80; valid0 = 1'b1; ptxt0 = 8'($urandom);
    predict();
    n_checks++;
    if ({ready1, ready0} !== 2'b00) begin
      n_fail++; $display("FAIL coll_ready: got %b want 00", {ready1, ready0});
    end
    advance();
    load0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p = 8'($urandom); ptxt0 = p;
      predict();
      n_checks++;
      if ({ready1, ready0} !== 2'b01) begin
        n_fail++; $display("FAIL coll_after_ready cyc %0d: got %b want 01", i, {ready1, ready0});
      end
      advance();
      n_checks++;
      if (dout_valid !== 1'b1 || ctxt_ch !== 1'b0 || ctxt !== (p ^ sb_ref[8'(8'h80 + i)])) begin
        n_fail++;
        $display("FAIL coll_out cyc %0d: got v=%b ch=%b c=%h want 1 0 %h", i, dout_valid, ctxt_ch, ctxt,
                 p ^ sb_ref[8'(8'h80 + i)]);
      end
    end
    idle_inputs();
    predict(); advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      load0  = ($urandom_range(15) == 0); key0 = 8'($urandom);
      load1  = ($urandom_range(15) == 0); key1 = 8'($urandom);
      valid0 = ($urandom_range(3) != 0);  ptxt0 = 8'($urandom);
      valid1 = ($urandom_range(3) != 0);  ptxt1 = 8'($urandom);
      dout_ready = ($urandom_range(3) != 0);
      predict();
      n_checks++;
      if ({ready1, ready0} !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", i, {ready1, ready0}, exp_rdy);
      end
      advance();
      n_checks++;
      if (dout_valid !== m_dv || (m_dv && {ctxt_ch, ctxt} !== {m_ch, m_ctxt})) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: got v=%b ch=%b c=%h want v=%b ch=%b c=%h", i, dout_valid, ctxt_ch,
                 ctxt, m_dv, m_ch, m_ctxt);
      end
    end
    idle_inputs();
    dout_ready = 1'b1;
    predict(); advance();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    load0 = 1'b1; key0 = 8'h33; load1 = 1'b1; key1 = 8'h44;
    predict(); advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      valid0 = 1'b1; valid1 = 1'b1; ptxt0 = 8'($urandom); ptxt1 = 8'($urandom);
      predict(); advance();
    end
    #2 rst_n = 1'b0;
    mdl_reset();
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || {ready1, ready0} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_async: got v=%b rdy=%b want 0 00", dout_valid, {ready1, ready0});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid0 = 1'b1; valid1 = 1'b1;
      predict();
      n_checks++;
      if ({ready1, ready0} !== 2'b00) begin
        n_fail++; $display("FAIL midrst_unkeyed cyc %0d: got %b want 00", i, {ready1, ready0});
      end
      advance();
    end
    load0 = 1'b1; load1 = 1'b1;
    predict(); advance();
    load0 = 1'b0; load1 = 1'b0;
    predict();
    n_checks++;
    if ({ready1, ready0} !== 2'b01) begin
      n_fail++; $display("FAIL midrst_first_grant: got %b want 01", {ready1, ready0});
    end
    advance();
    n_checks++;
    if (dout_valid !== 1'b1 || {ctxt_ch, ctxt} !== {m_ch, m_ctxt} || ctxt_ch !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_first_out: got v=%b ch=%b c=%h want 1 0 %h", dout_valid, ctxt_ch, ctxt, m_ctxt);
    end
    idle_inputs();
    predict(); advance();
  endtask

  initial begin
    for (int x = 0; x < 256; x++) sb_ref[x] = ref_sbox(8'(x));
    mdl_reset();
    test_reset();
    test_single_channel();
    test_wrap();
    test_fairness();
    test_back_to_back_backpressure();
    test_load_collision();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
